// File: rtl/ultrasonic_pkg.sv
// Shared constants for the ultrasonic echo responder: state encoding,
// sensor timing constants and a distance range helper.
package ultrasonic_pkg;

   // State encoding for the responder FSM
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_TRIG_MEAS = 3'd1;
   localparam state_t ST_BURST     = 3'd2;
   localparam state_t ST_ECHO      = 3'd3;
   localparam state_t ST_HOLDOFF   = 3'd4;

   // Round-trip time of sound per centimetre of target distance, in us
   localparam int US_PER_CM   = 58;
   localparam int MIN_CM      = 2;
   localparam int MAX_CM      = 400;
   // Echo width a real sensor reports when nothing reflects the burst
   localparam int TIMEOUT_US  = 38000;
   // Shortest trigger pulse the sensor accepts
   localparam int TRIG_MIN_US = 10;

   function automatic logic cm_in_range(input logic [8:0] cm);
      return (cm >= 9'(MIN_CM)) && (cm <= 9'(MAX_CM));
   endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler. Emits a one-cycle tick on the last clk cycle of
// every microsecond. 'clear' restarts the microsecond so a timed state
// entered on the clearing edge sees its first tick exactly CYCLES_PER_US
// cycles later.
module us_tick_gen #(
   parameter int CYCLES_PER_US = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
   localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_US - 1);

   logic [CW-1:0] cnt;

   // Free-running modulo-CYCLES_PER_US cycle counter, restartable
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// Ultrasonic ranging sensor emulator. Measures the trigger pulse, waits the
// burst time, returns an echo pulse whose width encodes distance_cm, then
// observes a hold-off dead time before accepting the next trigger.
// Optional feature macro: ECHO_TIMEOUT_EN -- when defined, an out-of-range
// distance returns a TIMEOUT_US wide echo instead of no echo at all.
module ultrasonic_echo_responder #(
   parameter int CYCLES_PER_US = 50,
   parameter int BURST_US      = 200,
   parameter int HOLDOFF_US    = 60000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Trigger,
   input  logic [8:0] distance_cm,
   output logic       Echo,
   output logic       busy,
   output logic       trig_err
);
   import ultrasonic_pkg::*;

   localparam logic [15:0] TRIG_MIN_CYC = 16'(TRIG_MIN_US * CYCLES_PER_US);
   localparam logic [16:0] BURST_DUR    = 17'(BURST_US);
   localparam logic [16:0] HOLD_DUR     = 17'(HOLDOFF_US);

   state_t      state;
   state_t      state_next;
   logic        trig_q;
   logic [15:0] trig_cnt;
   logic [15:0] us_cnt;
   logic [8:0]  latched_cm;
   logic        us_tick;
   logic        trig_rise;
   logic        in_range;
   logic        dur_done;
   logic [16:0] echo_dur;
   logic [16:0] dur_us;

   assign trig_rise = Trigger & ~trig_q;
   assign in_range  = cm_in_range(latched_cm);

`ifdef ECHO_TIMEOUT_EN
   localparam logic [16:0] TIMEOUT_DUR = 17'(TIMEOUT_US);
   assign echo_dur = in_range ? (17'(latched_cm) * 17'(US_PER_CM)) : TIMEOUT_DUR;
`else
   assign echo_dur = 17'(latched_cm) * 17'(US_PER_CM);
`endif

   // Length in us of the timed state currently active
   always_comb begin
      dur_us = HOLD_DUR;
      case (state)
         ST_BURST: dur_us = BURST_DUR;
         ST_ECHO:  dur_us = echo_dur;
         default:  dur_us = HOLD_DUR;
      endcase
   end

   // The last tick of the final microsecond ends the timed state
   assign dur_done = us_tick && ({1'b0, us_cnt} == (dur_us - 17'd1));

   // Next-state logic; trigger activity is only looked at in IDLE/TRIG_MEAS
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (trig_rise) state_next = ST_TRIG_MEAS;
         end
         ST_TRIG_MEAS: begin
            if (!Trigger) state_next = (trig_cnt >= TRIG_MIN_CYC) ? ST_BURST : ST_IDLE;
         end
         ST_BURST: begin
`ifdef ECHO_TIMEOUT_EN
            if (dur_done) state_next = ST_ECHO;
`else
            if (dur_done) state_next = in_range ? ST_ECHO : ST_HOLDOFF;
`endif
         end
         ST_ECHO: begin
            if (dur_done) state_next = ST_HOLDOFF;
         end
         ST_HOLDOFF: begin
            if (dur_done) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Prescaler restarts on every state change
   us_tick_gen #(.CYCLES_PER_US(CYCLES_PER_US)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (state_next != state),
      .tick  (us_tick)
   );

   // State register, trigger edge detector and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         trig_q   <= 1'b0;
         Echo     <= 1'b0;
         busy     <= 1'b0;
         trig_err <= 1'b0;
      end else begin
         state    <= state_next;
         trig_q   <= Trigger;
         Echo     <= (state_next == ST_ECHO);
         busy     <= (state_next != ST_IDLE);
         trig_err <= (state == ST_TRIG_MEAS) && !Trigger && (trig_cnt < TRIG_MIN_CYC);
      end
   end

   // Trigger width counter: counts high samples, saturating
   always_ff @(posedge clk) begin
      if (rst) begin
         trig_cnt <= '0;
      end else if (state == ST_IDLE && trig_rise) begin
         trig_cnt <= 16'd1;
      end else if (state == ST_TRIG_MEAS && Trigger && trig_cnt != 16'hFFFF) begin
         trig_cnt <= trig_cnt + 16'd1;
      end
   end

   // Distance is captured once per accepted trigger and held for the pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         latched_cm <= '0;
      end else if (state == ST_TRIG_MEAS && state_next == ST_BURST) begin
         latched_cm <= distance_cm;
      end
   end

   // Elapsed microseconds within the current timed state
   always_ff @(posedge clk) begin
      if (rst || (state_next != state)) begin
         us_cnt <= '0;
      end else if (us_tick) begin
         us_cnt <= us_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Directed bench for ultrasonic_echo_responder with scaled-down timing.
// A timestamp model predicts Echo/busy/trig_err every cycle; literal
// expectations pin pulse positions and widths for each scenario.
module tb_ultrasonic_echo_responder;

`ifdef ECHO_TIMEOUT_EN
   localparam int CPU  = 1;
   localparam int BC   = 5;       // 5 us burst
   localparam int HC   = 20;      // 20 us hold-off
   localparam int TMIN = 10;      // 10 us minimum trigger
   localparam int W100 = 5800;
   localparam int W2   = 116;
   localparam int W400 = 23200;
   localparam int W20  = 1160;
   localparam int W500 = 38000;
`else
   localparam int CPU  = 2;
   localparam int BC   = 10;
   localparam int HC   = 40;
   localparam int TMIN = 20;
   localparam int W100 = 11600;
   localparam int W2   = 232;
   localparam int W400 = 46400;
   localparam int W20  = 2320;
   localparam int W500 = 0;
`endif
   localparam int BURST_US   = 5;
   localparam int HOLDOFF_US = 20;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic       Trigger;
   logic [8:0] distance_cm;
   logic       Echo;
   logic       busy;
   logic       trig_err;

   always #5 clk = ~clk;

   ultrasonic_echo_responder #(
      .CYCLES_PER_US (CPU),
      .BURST_US      (BURST_US),
      .HOLDOFF_US    (HOLDOFF_US)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .Trigger     (Trigger),
      .distance_cm (distance_cm),
      .Echo        (Echo),
      .busy        (busy),
      .trig_err    (trig_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   int cyc = 0;
   bit model_valid = 0;
   bit exp_echo = 0, exp_busy = 0, exp_err = 0;
   bit m_prev_trig = 0, m_meas = 0, m_sched = 0;
   int m_hi = 0, t_rise = 0, t_fall = 0, t_idle = 0;

   function automatic int echo_us(input int cm);
      if (cm >= 2 && cm <= 400) return cm * 58;
`ifdef ECHO_TIMEOUT_EN
      return 38000;
`else
      return 0;
`endif
   endfunction

   // Outputs after edge number cyc, derived from event timestamps
   always @(posedge clk) begin
      cyc++;
      exp_err = 0;
      if (rst) begin
         m_sched = 0; m_meas = 0; m_hi = 0;
         exp_echo = 0; exp_busy = 0;
         m_prev_trig = 0;
      end else begin
         if (m_sched) begin
            if (cyc >= t_idle) begin
               m_sched = 0; exp_busy = 0; exp_echo = 0;
            end else begin
               exp_busy = 1;
               exp_echo = (cyc >= t_rise) && (cyc < t_fall);
            end
         end else if (m_meas) begin
            if (Trigger) m_hi++;
            else begin
               m_meas = 0;
               if (m_hi >= 10 * CPU) begin
                  m_sched = 1;
                  t_rise  = cyc + BURST_US * CPU;
                  t_fall  = t_rise + echo_us(int'(distance_cm)) * CPU;
                  t_idle  = t_fall + HOLDOFF_US * CPU;
                  exp_busy = 1;
               end else begin
                  exp_err = 1; exp_busy = 0;
               end
            end
         end else if (Trigger && !m_prev_trig) begin
            m_meas = 1; m_hi = 1; exp_busy = 1;
         end
         m_prev_trig = Trigger;
      end
      model_valid = 1;
   end

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      if (model_valid) begin
         check("echo_model", Echo, exp_echo);
         check("busy_model", busy, exp_busy);
         check("trig_err_model", trig_err, exp_err);
      end
   end

   // ---------------- edge monitor ----------------
   int rise_cyc = 0, fall_cyc = 0, busy_fall_cyc = 0, n_rise = 0, n_err = 0;
   logic mon_echo = 0, mon_busy = 0;

   always begin
      @(posedge clk);
      #1;
      if (Echo === 1'b1 && mon_echo === 1'b0) begin rise_cyc = cyc; n_rise++; end
      if (Echo === 1'b0 && mon_echo === 1'b1) fall_cyc = cyc;
      if (busy === 1'b0 && mon_busy === 1'b1) busy_fall_cyc = cyc;
      if (trig_err === 1'b1) n_err++;
      mon_echo = Echo;
      mon_busy = busy;
   end

   // ---------------- driver tasks ----------------
   int t_low = 0;

   task automatic pulse(input int n);
      Trigger = 1'b1;
      repeat (n) @(negedge clk);
      Trigger = 1'b0;
      t_low = cyc + 1;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while (busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
      check(name, busy, 0);
   endtask

   task automatic wait_echo(input logic lvl, input int budget, input string name);
      int k = 0;
      while (Echo !== lvl && k < budget) begin @(negedge clk); k++; end
      check(name, Echo, lvl);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int e0, r0;
      rst = 1'b1; Trigger = 1'b0; distance_cm = 9'd100;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_echo", Echo, 0);
      check("reset_busy", busy, 0);
      check("reset_trig_err", trig_err, 0);

      // Minimum-width valid trigger, 100 cm
      pulse(TMIN);
      wait_idle(W100 + BC + HC + 100, "t1_idle");
      check("t1_burst_delay", rise_cyc - t_low, BC);
      check("t1_width", fall_cyc - rise_cyc, W100);
      check("t1_holdoff", busy_fall_cyc - fall_cyc, HC);
      check("t1_no_err", n_err, 0);

      // One cycle short: rejected
      e0 = n_err; r0 = n_rise;
      pulse(TMIN - 1);
      repeat (3) @(negedge clk);
      check("t2_err_pulse", n_err - e0, 1);
      check("t2_no_echo", n_rise - r0, 0);
      check("t2_busy", busy, 0);

      // Range boundaries
      distance_cm = 9'd2;
      pulse(TMIN);
      wait_idle(W2 + BC + HC + 100, "t3a_idle");
      check("t3a_width_2cm", fall_cyc - rise_cyc, W2);
      distance_cm = 9'd400;
      pulse(TMIN);
      wait_idle(W400 + BC + HC + 100, "t3b_idle");
      check("t3b_width_400cm", fall_cyc - rise_cyc, W400);
      check("t3b_burst_delay", rise_cyc - t_low, BC);

      // Out of range
      distance_cm = 9'd500;
      r0 = n_rise;
      pulse(TMIN);
      wait_idle(W500 + BC + HC + 100, "t4_idle");
      check("t4_echo_count", n_rise - r0, (W500 > 0) ? 1 : 0);
      check("t4_busy_span", busy_fall_cyc - t_low, BC + W500 + HC);

      // Trigger and distance changes during ECHO are ignored
      distance_cm = 9'd20;
      e0 = n_err;
      pulse(TMIN);
      wait_echo(1'b1, BC + 50, "t5_echo_rise");
      repeat (50) @(negedge clk);
      distance_cm = 9'd10;
      pulse(TMIN);
      distance_cm = 9'd300;
      wait_idle(W20 + BC + HC + 100, "t5_idle");
      check("t5_width", fall_cyc - rise_cyc, W20);
      check("t5_no_err", n_err - e0, 0);

      // Reset mid-ECHO, Trigger held high across release counts as an edge
      distance_cm = 9'd20;
      pulse(TMIN);
      wait_echo(1'b1, BC + 50, "t6_echo_rise");
      repeat (100) @(negedge clk);
      rst = 1'b1; Trigger = 1'b1;
      @(negedge clk);
      check("t6_echo_dropped", Echo, 0);
      check("t6_busy_dropped", busy, 0);
      rst = 1'b0;
      repeat (TMIN) @(negedge clk);
      Trigger = 1'b0;
      t_low = cyc + 1;
      wait_idle(W20 + BC + HC + 100, "t6_idle");
      check("t6_width", fall_cyc - rise_cyc, W20);
      check("t6_burst_delay", rise_cyc - t_low, BC);

      // Trigger already high when IDLE is re-entered is not an edge
      distance_cm = 9'd2;
      pulse(TMIN);
      wait_echo(1'b1, BC + 50, "t7_echo_rise");
      wait_echo(1'b0, W2 + 50, "t7_echo_fall");
      Trigger = 1'b1;
      r0 = n_rise;
      wait_idle(HC + 50, "t7_idle");
      repeat (5) @(negedge clk);
      check("t7_held_trigger_ignored", busy, 0);
      Trigger = 1'b0;
      repeat (3) @(negedge clk);
      check("t7_still_idle", busy, 0);
      check("t7_no_echo", n_rise - r0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
